frac_round_sat: RTL

Fixed-point post-multiply rescaling stage. Consumes the signed double-width product of the booth/Wallace fractional multiplier, Q(2·INT).(2·FRAC), and returns it to the working format Q(INT).(FRAC) with selectable rounding and signed saturation. Two-stage elastic pipeline with valid/ready handshakes on both sides, plus a sticky overflow flag and a saturating overflow event counter for the vector lane.

---
 rtl/frac_round_sat_pkg.sv | 18 +
 rtl/fp_round_unit.sv | 35 +++
 rtl/frac_round_sat.sv | 87 ++++++++
 3 files changed

// File: rtl/frac_round_sat_pkg.sv
// frac_round_sat_pkg: shared fixed-point round modes and representable-range helpers.
package frac_round_sat_pkg;

    typedef enum logic [1:0] {
        RND_TRUNC     = 2'd0,
        RND_HALF_UP   = 2'd1,
        RND_HALF_EVEN = 2'd2
    } round_mode_e;

    function automatic logic signed [63:0] fp_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] fp_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/fp_round_unit.sv
// fp_round_unit: combinational rescale of a Q(2I).(2F) product to Q(2I).(F) with rounding.
module fp_round_unit
    import frac_round_sat_pkg::*;
#(
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 8
) (
    input  logic [2*(INT_WIDTH+FRAC_WIDTH)-1:0]          product,
    input  logic [1:0]                                   mode,
    output logic [2*(INT_WIDTH+FRAC_WIDTH)-FRAC_WIDTH:0] r
);
    localparam int W  = INT_WIDTH + FRAC_WIDTH;
    localparam int QW = 2 * W - FRAC_WIDTH;

    logic [QW-1:0] q;
    logic          lsb, guard, sticky, inc;

    assign q     = product[2*W-1:FRAC_WIDTH];
    assign lsb   = product[FRAC_WIDTH];
    assign guard = product[FRAC_WIDTH-1];

    if (FRAC_WIDTH > 1) begin : g_sticky
        assign sticky = |product[FRAC_WIDTH-2:0];
    end else begin : g_no_sticky
        assign sticky = 1'b0;
    end

    // Reserved mode 3 falls through to truncation.
    assign inc = (mode == RND_HALF_UP)   ? guard :
                 (mode == RND_HALF_EVEN) ? guard & (sticky | lsb) : 1'b0;

    // One extra bit of headroom so the increment can never wrap.
    assign r = {q[QW-1], q} + {{QW{1'b0}}, inc};

endmodule

// File: rtl/frac_round_sat.sv
// frac_round_sat: two-stage elastic round + saturate stage with sticky flag and overflow counter.
module frac_round_sat
    import frac_round_sat_pkg::*;
#(
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [2*(INT_WIDTH+FRAC_WIDTH)-1:0]   product,
    input  logic [1:0]                            round_mode,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [INT_WIDTH+FRAC_WIDTH-1:0]       result,
    output logic                                  ovf,
    output logic                                  ovf_sticky,
    output logic [CNT_WIDTH-1:0]                  ovf_count,
    input  logic                                  clr
);
    localparam int W  = INT_WIDTH + FRAC_WIDTH;
    localparam int RW = 2 * W - FRAC_WIDTH + 1;
    localparam logic signed [RW-1:0] R_MAX = RW'(fp_max(W));
    localparam logic signed [RW-1:0] R_MIN = RW'(fp_min(W));
    localparam logic [W-1:0]         W_MAX = W'(fp_max(W));
    localparam logic [W-1:0]         W_MIN = W'(fp_min(W));

    logic [RW-1:0]        r;
    logic signed [RW-1:0] s1_r;
    logic                 s1_valid, s2_load, hi, lo, fire;

    fp_round_unit #(
        .INT_WIDTH (INT_WIDTH),
        .FRAC_WIDTH(FRAC_WIDTH)
    ) u_round (
        .product(product),
        .mode   (round_mode),
        .r      (r)
    );

    assign s2_load  = !out_valid | out_ready;
    assign in_ready = !s1_valid | s2_load;
    assign hi       = s1_r > R_MAX;
    assign lo       = s1_r < R_MIN;
    assign fire     = out_valid & out_ready & ovf;

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) s1_r <= r;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            ovf       <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result <= hi ? W_MAX : lo ? W_MIN : s1_r[W-1:0];
                ovf    <= hi | lo;
            end
        end
    end

    // A clear in the same cycle as an overflow accept takes priority.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else if (clr) begin
            ovf_sticky <= 1'b0;
            ovf_count  <= '0;
        end else if (fire) begin
            ovf_sticky <= 1'b1;
            if (!(&ovf_count)) ovf_count <= ovf_count + 1'b1;
        end
    end

endmodule
